// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
// Segment patterns are ordered segment 7 (middle) down to segment 1 (top).
package seg7_pkg;

    typedef enum logic [1:0] {
        SHOW_U  = 2'd0,
        BLANK_A = 2'd1,
        SHOW_T  = 2'd2,
        BLANK_B = 2'd3
    } scan_state_e;

    localparam int DEF_SCAN_DIV     = 1000;
    localparam int DEF_BLANK_CYCLES = 8;
    localparam int CONV_CYCLES      = 7;

    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111100;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1100111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [1:0] EN_OFF   = 2'b00;
    localparam logic [1:0] EN_UNITS = 2'b01;
    localparam logic [1:0] EN_TENS  = 2'b10;

    // One double-dabble step on a {tens,units} pair: correct digits >= 5, then shift in bit_in.
    function automatic logic [7:0] add3_shift(input logic [7:0] bcd, input logic bit_in);
        logic [3:0] u;
        logic [3:0] t;
        logic [7:0] adj;
        u = bcd[3:0];
        t = bcd[7:4];
        if (u >= 4'd5) u = u + 4'd3;
        if (t >= 4'd5) t = t + 4'd3;
        adj = {t, u};
        return (adj << 1) | {7'd0, bit_in};
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_dec.sv
// Combinational BCD nibble to 7-segment pattern decoder; codes above 9 go dark.
module seg7_scan_ctrl_dec
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Two-digit 7-segment scan controller: sequential binary-to-BCD conversion with a
// one-entry pending slot, and a free-running units/blank/tens/blank scan FSM.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] value,
    input  logic       load,
    output logic [6:0] segments,
    output logic [1:0] digit_en,
    output logic       busy
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(CONV_CYCLES + 1);

    localparam logic [CW-1:0] SHOW_LEN  = CW'(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LEN = CW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BITS_LEN  = BW'(CONV_CYCLES);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          busy_q, busy_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]    bin_q, bin_d;
    logic [7:0]    work_q, work_d;
    logic [7:0]    disp_q, disp_d;
    logic          pend_vld_q, pend_vld_d;
    logic [6:0]    pend_q, pend_d;

    logic [6:0]    seg_q, seg_d;
    logic [1:0]    en_q, en_d;

    logic [6:0]    sat_value;
    logic [7:0]    work_next;
    logic          conv_done;
    logic [3:0]    digit_sel;
    logic [6:0]    dec_seg;

    // Conversion engine; display registers are only written on the final step.
    always_comb begin
        sat_value  = (value > 7'd99) ? 7'd99 : value;
        work_next  = add3_shift(work_q, bin_q[6]);
        conv_done  = busy_q && (bit_cnt_q == BW'(1));

        busy_d     = busy_q;
        bit_cnt_d  = bit_cnt_q;
        bin_d      = bin_q;
        work_d     = work_q;
        disp_d     = disp_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;

        if (busy_q) begin
            work_d    = work_next;
            bin_d     = {bin_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BW'(1);
            if (conv_done) begin
                disp_d = work_next;
                // A load landing on the completion edge is newer than anything pending.
                if (load) begin
                    bin_d      = sat_value;
                    work_d     = 8'd0;
                    bit_cnt_d  = BITS_LEN;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    bin_d      = pend_q;
                    work_d     = 8'd0;
                    bit_cnt_d  = BITS_LEN;
                    pend_vld_d = 1'b0;
                end else begin
                    busy_d = 1'b0;
                end
            end else if (load) begin
                pend_d     = sat_value;
                pend_vld_d = 1'b1;
            end
        end else if (load) begin
            busy_d    = 1'b1;
            bin_d     = sat_value;
            work_d    = 8'd0;
            bit_cnt_d = BITS_LEN;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
            case (state_q)
                SHOW_U:  begin state_d = BLANK_A; cnt_d = BLANK_LEN; end
                BLANK_A: begin state_d = SHOW_T;  cnt_d = SHOW_LEN;  end
                SHOW_T:  begin state_d = BLANK_B; cnt_d = BLANK_LEN; end
                default: begin state_d = SHOW_U;  cnt_d = SHOW_LEN;  end
            endcase
        end
    end

    assign digit_sel = (state_q == SHOW_T) ? disp_q[7:4] : disp_q[3:0];

    seg7_scan_ctrl_dec u_dec (
        .digit (digit_sel),
        .seg   (dec_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        en_d  = EN_OFF;
        case (state_q)
            SHOW_U: begin
                seg_d = dec_seg;
                en_d  = EN_UNITS;
            end
            SHOW_T: begin
                if (disp_q[7:4] != 4'd0) begin
                    seg_d = dec_seg;
                    en_d  = EN_TENS;
                end
            end
            default: begin
                seg_d = SEG_OFF;
                en_d  = EN_OFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SHOW_U;
            cnt_q      <= SHOW_LEN;
            busy_q     <= 1'b0;
            bit_cnt_q  <= '0;
            bin_q      <= '0;
            work_q     <= '0;
            disp_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            seg_q      <= SEG_OFF;
            en_q       <= EN_OFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            bit_cnt_q  <= bit_cnt_d;
            bin_q      <= bin_d;
            work_q     <= work_d;
            disp_q     <= disp_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            seg_q      <= seg_d;
            en_q       <= en_d;
        end
    end

    assign segments = seg_q;
    assign digit_en = en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random loads/resets, all checked
// against a cycle-count and integer-arithmetic model of the display.
module tb_seg7_scan_ctrl;

    localparam int S   = 4;
    localparam int B   = 2;
    localparam int PER = 2 * S + 2 * B;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [6:0] value = 7'd0;
    logic [6:0] segments;
    logic [1:0] digit_en;
    logic       busy;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .segments (segments),
        .digit_en (digit_en),
        .busy     (busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                             7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111};

    int m_t = 0, m_disp = 0, m_job = 0, m_rem = 0, m_pend = 0;
    bit m_busy = 0, m_pend_vld = 0;
    logic [6:0] exp_seg = '0;
    logic [1:0] exp_en = '0;
    logic       exp_busy = 1'b0;

    // Drive one cycle, advance the model across the edge, and settle 1 time unit past it.
    task automatic step(input logic r, input logic l, input int v);
        int p;
        int sat;
        @(negedge clk);
        reset = r;
        load  = l;
        value = 7'(v);
        @(posedge clk);
        sat = (v > 99) ? 99 : v;
        if (r) begin
            m_t = 0; m_disp = 0; m_busy = 0; m_pend_vld = 0; m_rem = 0;
            exp_seg = '0; exp_en = '0;
        end else begin
            p = m_t % PER;
            exp_seg = '0; exp_en = '0;
            if (p < S) begin
                exp_en = 2'b01; exp_seg = pat[m_disp % 10];
            end else if (p >= S + B && p < 2 * S + B && (m_disp / 10) != 0) begin
                exp_en = 2'b10; exp_seg = pat[m_disp / 10];
            end
            m_t++;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_disp = m_job;
                    if (l) begin
                        m_job = sat; m_rem = 7; m_pend_vld = 0;
                    end else if (m_pend_vld) begin
                        m_job = m_pend; m_rem = 7; m_pend_vld = 0;
                    end else begin
                        m_busy = 0;
                    end
                end else if (l) begin
                    m_pend = sat; m_pend_vld = 1;
                end
            end else if (l) begin
                m_busy = 1; m_job = sat; m_rem = 7;
            end
        end
        exp_busy = m_busy;
        #1;
    endtask

    task automatic test_reset();
        int n_units = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 55);
            n_chk++;
            if ({segments, digit_en, busy} !== 10'b0) begin
                n_fail++;
                $display("FAIL reset_state: seg=%b en=%b busy=%b, expected 0000000 00 0",
                         segments, digit_en, busy);
            end
        end
        step(1'b0, 1'b0, 0);
        n_chk++;
        if (segments !== 7'b0111111 || digit_en !== 2'b01) begin
            n_fail++;
            $display("FAIL first_edge: seg=%b en=%b, expected 0111111 01", segments, digit_en);
        end
        if (digit_en === 2'b01) n_units++;
        for (int i = 1; i < 2 * PER; i++) begin
            step(1'b0, 1'b0, 0);
            if (digit_en === 2'b01) n_units++;
            n_chk++;
            if ({segments, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL scan_period cyc%0d: seg=%b en=%b busy=%b, expected seg=%b en=%b busy=%b",
                         i, segments, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        n_chk++;
        if (n_units != 2 * S) begin
            n_fail++;
            $display("FAIL units_count: got %0d, expected %0d", n_units, 2 * S);
        end
    endtask

    task automatic test_latency();
        bit seen = 0;
        step(1'b0, 1'b1, 57);
        for (int i = 0; i < 7 + PER + 1; i++) begin
            if (i > 0) step(1'b0, 1'b0, 0);
            n_chk++;
            if (busy !== (i < 7) || {segments, digit_en} !== {exp_seg, exp_en}) begin
                n_fail++;
                $display("FAIL latency cyc%0d: seg=%b en=%b busy=%b, expected seg=%b en=%b busy=%b",
                         i, segments, digit_en, busy, exp_seg, exp_en, (i < 7));
            end
            if (digit_en === 2'b10 && segments === 7'b1101101) seen = 1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL latency_tens: tens digit 5 pattern seen=%0d, expected 1", seen);
        end
    endtask

    task automatic test_saturation();
        bit seen_u = 0, seen_t = 0;
        step(1'b0, 1'b1, 127);
        for (int i = 0; i < 8 + PER; i++) begin
            step(1'b0, 1'b0, 0);
            n_chk++;
            if ({segments, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL saturation cyc%0d: seg=%b en=%b busy=%b, expected seg=%b en=%b busy=%b",
                         i, segments, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
            if (segments === 7'b1100111 && digit_en === 2'b01) seen_u = 1;
            if (segments === 7'b1100111 && digit_en === 2'b10) seen_t = 1;
        end
        n_chk++;
        if (!(seen_u && seen_t)) begin
            n_fail++;
            $display("FAIL saturation_99: units9=%0d tens9=%0d, expected 1 1", seen_u, seen_t);
        end
    endtask

    task automatic test_pending();
        int n_busy = 0;
        bit seen34 = 0;
        int loads [4] = '{12, 0, 34, 56};
        for (int i = 0; i < 20 + 2 * PER; i++) begin
            step(1'b0, (i < 4) && (i != 1), (i < 4) ? loads[i] : 0);
            if (busy === 1'b1) n_busy++;
            if (digit_en === 2'b10 && segments === pat[3]) seen34 = 1;
            n_chk++;
            if ({segments, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL pending cyc%0d: seg=%b en=%b busy=%b, expected seg=%b en=%b busy=%b",
                         i, segments, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        n_chk++;
        if (n_busy != 14 || seen34) begin
            n_fail++;
            $display("FAIL pending_overwrite: busy_cycles=%0d shown34=%0d, expected 14 0", n_busy, seen34);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_tens = 0;
        step(1'b0, 1'b1, 88);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        n_chk++;
        if ({segments, digit_en, busy} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_mid: seg=%b en=%b busy=%b, expected 0000000 00 0",
                     segments, digit_en, busy);
        end
        for (int i = 0; i < 2 * PER; i++) begin
            step(1'b0, 1'b0, 0);
            if (digit_en === 2'b10 || segments === pat[8]) seen_tens = 1;
            n_chk++;
            if ({segments, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL reset_mid_scan cyc%0d: seg=%b en=%b busy=%b, expected seg=%b en=%b busy=%b",
                         i, segments, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        n_chk++;
        if (seen_tens) begin
            n_fail++;
            $display("FAIL reset_mid_88: aborted value shown=%0d, expected 0", seen_tens);
        end
    endtask

    task automatic test_leading_zero();
        bit seen7 = 0, seen_tens = 0;
        step(1'b0, 1'b1, 7);
        for (int i = 0; i < 7 + 2 * PER; i++) begin
            step(1'b0, 1'b0, 0);
            if (i > 7 && digit_en === 2'b01 && segments === 7'b0000111) seen7 = 1;
            if (digit_en === 2'b10) seen_tens = 1;
            n_chk++;
            if ({segments, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
                n_fail++;
                $display("FAIL leading_zero cyc%0d: seg=%b en=%b busy=%b, expected seg=%b en=%b busy=%b",
                         i, segments, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
        n_chk++;
        if (!seen7 || seen_tens) begin
            n_fail++;
            $display("FAIL leading_zero_blank: units7=%0d tens_lit=%0d, expected 1 0", seen7, seen_tens);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 127)));
            n_chk++;
            if ({segments, digit_en, busy} !== {exp_seg, exp_en, exp_busy} || digit_en === 2'b11) begin
                n_fail++;
                $display("FAIL random cyc%0d: seg=%b en=%b busy=%b, expected seg=%b en=%b busy=%b",
                         i, segments, digit_en, busy, exp_seg, exp_en, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_saturation();
        test_pending();
        test_reset_mid();
        test_leading_zero();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
